// File: rtl/c906_mmu_mbist_pkg.sv
// Shared encodings for the JTLB March C- MBIST controller.
package c906_mmu_mbist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      ELEM_E0 = 3'd0,
      ELEM_E1 = 3'd1,
      ELEM_E2 = 3'd2,
      ELEM_E3 = 3'd3,
      ELEM_E4 = 3'd4,
      ELEM_E5 = 3'd5
   } elem_e;

   // Per-element tables, bit index = element number; read/write polarity 1 means ~B.
   localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
   localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
   localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;
   localparam logic [7:0] ELEM_RD_INV = 8'b0001_0100;
   localparam logic [7:0] ELEM_WR_INV = 8'b0000_1010;

   localparam int unsigned CKBD_MAX_W = 128;

   function automatic logic [CKBD_MAX_W-1:0] ckbd_word(input logic odd_addr);
      return odd_addr ? {(CKBD_MAX_W/2){2'b10}} : {(CKBD_MAX_W/2){2'b01}};
   endfunction

endpackage

// File: rtl/c906_mmu_mbist_cmp.sv
// Read-compare pipeline aligned to SRAM read latency, with first-failure capture.
module c906_mmu_mbist_cmp
   import c906_mmu_mbist_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 88,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_exp,
   input  logic [ADDR_WIDTH-1:0] push_addr,
   input  logic [3:0]            push_elem,
   input  logic [DATA_WIDTH-1:0] sram_q,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [3:0]            fail_elem,
   output logic                  mismatch_c
);

   localparam int unsigned LAST = RD_LAT - 1;

   logic                  vld_q  [RD_LAT];
   logic                  vld_d  [RD_LAT];
   logic [DATA_WIDTH-1:0] exp_q  [RD_LAT];
   logic [DATA_WIDTH-1:0] exp_d  [RD_LAT];
   logic [ADDR_WIDTH-1:0] addr_q [RD_LAT];
   logic [ADDR_WIDTH-1:0] addr_d [RD_LAT];
   logic [3:0]            elem_q [RD_LAT];
   logic [3:0]            elem_d [RD_LAT];

   logic                  fail_q, fail_d;
   logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
   logic [3:0]            fail_elem_q, fail_elem_d;

   always_comb begin
      vld_d[0]  = push;
      exp_d[0]  = push_exp;
      addr_d[0] = push_addr;
      elem_d[0] = push_elem;
      for (int i = 1; i < int'(RD_LAT); i++) begin
         vld_d[i]  = vld_q[i-1];
         exp_d[i]  = exp_q[i-1];
         addr_d[i] = addr_q[i-1];
         elem_d[i] = elem_q[i-1];
      end

      // Only the first mismatch is reported; later in-flight ones are dropped.
      mismatch_c  = vld_q[LAST] && (sram_q != exp_q[LAST]) && !fail_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      if (clr) begin
         fail_d      = 1'b0;
         fail_addr_d = '0;
         fail_elem_d = '0;
      end else if (mismatch_c) begin
         fail_d      = 1'b1;
         fail_addr_d = addr_q[LAST];
         fail_elem_d = elem_q[LAST];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            vld_q[i]  <= 1'b0;
            exp_q[i]  <= '0;
            addr_q[i] <= '0;
            elem_q[i] <= '0;
         end
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
      end else begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            vld_q[i]  <= vld_d[i];
            exp_q[i]  <= exp_d[i];
            addr_q[i] <= addr_d[i];
            elem_q[i] <= elem_d[i];
         end
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
      end
   end

   assign fail      = fail_q;
   assign fail_addr = fail_addr_q;
   assign fail_elem = fail_elem_q;

endmodule

// File: rtl/c906_mmu_mbist_ctrl.sv
// March C- MBIST controller for one JTLB SRAM; MMU_MBIST_CKBD_EN adds a checkerboard pass.
module c906_mmu_mbist_ctrl
   import c906_mmu_mbist_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DATA_WIDTH = 88,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic                  forever_clk,
   input  logic                  forever_rst,
   input  logic                  bist_start,
   output logic                  bist_busy,
   output logic                  bist_done,
   output logic                  bist_pass,
   output logic [ADDR_WIDTH-1:0] bist_fail_addr,
   output logic [3:0]            bist_fail_elem,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

`ifdef MMU_MBIST_CKBD_EN
   localparam logic CKBD_EN = 1'b1;
`else
   localparam logic CKBD_EN = 1'b0;
`endif
   localparam int unsigned DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_e                state_q, state_d;
   elem_e                 elem_q, elem_d, nxt_elem;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  ph_q, ph_d;
   logic                  bg_q, bg_d;
   logic [DRAIN_W-1:0]    drain_q, drain_d;
   logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [ADDR_WIDTH-1:0] sram_a_q, sram_a_d;
   logic                  sram_cen_q, sram_cen_d, sram_gwen_q, sram_gwen_d;
   logic [DATA_WIDTH-1:0] sram_wen_q, sram_wen_d, sram_d_q, sram_d_d;
   logic                  rd_q, rd_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d, pat;
   logic [3:0]            tag_elem_q, tag_elem_d;
   logic                  issue, clr, last_addr, slot_end, run_end;
   logic                  fail, mismatch_c;

   // Cursor (bg, elem, addr, ph) names the op currently on the SRAM pins; ph=1 is the write slot.
   always_comb begin
      state_d  = state_q;
      elem_d   = elem_q;
      addr_d   = addr_q;
      ph_d     = ph_q;
      bg_d     = bg_q;
      drain_d  = drain_q;
      issue    = 1'b0;
      clr      = 1'b0;
      nxt_elem = (elem_q == ELEM_E5) ? ELEM_E0 : elem_e'(elem_q + 3'd1);
      last_addr = ELEM_DOWN[elem_q] ? (addr_q == '0) : (addr_q == '1);
      slot_end  = ph_q || !ELEM_HAS_WR[elem_q];
      run_end   = slot_end && last_addr && (elem_q == ELEM_E5) && (bg_q || !CKBD_EN);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bist_start) begin
               state_d = ST_RUN;
               clr     = 1'b1;
               elem_d  = ELEM_E0;
               addr_d  = '0;
               ph_d    = 1'b1;
               bg_d    = 1'b0;
               issue   = 1'b1;
            end
         end
         ST_RUN: begin
            if (mismatch_c || run_end) begin
               state_d = ST_DRAIN;
               drain_d = '0;
            end else begin
               issue = 1'b1;
               if (!slot_end) begin
                  ph_d = 1'b1;
               end else if (!last_addr) begin
                  addr_d = ELEM_DOWN[elem_q] ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
                  ph_d   = !ELEM_HAS_RD[elem_q];
               end else begin
                  elem_d = nxt_elem;
                  bg_d   = bg_q || (elem_q == ELEM_E5);
                  addr_d = ELEM_DOWN[nxt_elem] ? '1 : '0;
                  ph_d   = !ELEM_HAS_RD[nxt_elem];
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_W'(RD_LAT - 1)) state_d = ST_DONE;
            else                                 drain_d = drain_q + DRAIN_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      sram_cen_d  = 1'b1;
      sram_gwen_d = 1'b1;
      sram_wen_d  = '1;
      sram_a_d    = sram_a_q;
      sram_d_d    = sram_d_q;
      rd_d        = 1'b0;
      exp_d       = exp_q;
      tag_elem_d  = tag_elem_q;
      pat         = bg_d ? DATA_WIDTH'(ckbd_word(addr_d[0])) : '0;
      if (issue) begin
         sram_cen_d = 1'b0;
         sram_a_d   = addr_d;
         if (ph_d) begin
            sram_gwen_d = 1'b0;
            sram_wen_d  = '0;
            sram_d_d    = pat ^ {DATA_WIDTH{ELEM_WR_INV[elem_d]}};
         end else begin
            rd_d       = 1'b1;
            exp_d      = pat ^ {DATA_WIDTH{ELEM_RD_INV[elem_d]}};
            tag_elem_d = {bg_d, elem_d};
         end
      end

      busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
      pass_d = (state_d == ST_DONE) && ((state_q == ST_DONE) ? pass_q : !(fail || mismatch_c));
   end

   always_ff @(posedge forever_clk) begin
      if (forever_rst) begin
         state_q     <= ST_IDLE;
         elem_q      <= ELEM_E0;
         addr_q      <= '0;
         ph_q        <= 1'b0;
         bg_q        <= 1'b0;
         drain_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         sram_a_q    <= '0;
         sram_cen_q  <= 1'b1;
         sram_gwen_q <= 1'b1;
         sram_wen_q  <= '1;
         sram_d_q    <= '0;
         rd_q        <= 1'b0;
         exp_q       <= '0;
         tag_elem_q  <= '0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         addr_q      <= addr_d;
         ph_q        <= ph_d;
         bg_q        <= bg_d;
         drain_q     <= drain_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         sram_a_q    <= sram_a_d;
         sram_cen_q  <= sram_cen_d;
         sram_gwen_q <= sram_gwen_d;
         sram_wen_q  <= sram_wen_d;
         sram_d_q    <= sram_d_d;
         rd_q        <= rd_d;
         exp_q       <= exp_d;
         tag_elem_q  <= tag_elem_d;
      end
   end

   c906_mmu_mbist_cmp #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LAT     (RD_LAT)
   ) u_cmp (
      .clk        (forever_clk),
      .rst        (forever_rst),
      .clr        (clr),
      .push       (rd_q),
      .push_exp   (exp_q),
      .push_addr  (sram_a_q),
      .push_elem  (tag_elem_q),
      .sram_q     (sram_q),
      .fail       (fail),
      .fail_addr  (bist_fail_addr),
      .fail_elem  (bist_fail_elem),
      .mismatch_c (mismatch_c)
   );

   assign bist_busy = busy_q;
   assign bist_done = done_q;
   assign bist_pass = pass_q;
   assign sram_a    = sram_a_q;
   assign sram_cen  = sram_cen_q;
   assign sram_gwen = sram_gwen_q;
   assign sram_wen  = sram_wen_q;
   assign sram_d    = sram_d_q;

endmodule

// File: tb/tb_c906_mmu_mbist_ctrl.sv
// Bench for c906_mmu_mbist_ctrl: behavioural SRAM with injectable faults and a March C- reference model.
module tb_c906_mmu_mbist_ctrl;

   localparam int unsigned AW     = 7;
   localparam int          DEPTH  = 1 << AW;
   localparam int unsigned RD_LAT = 1;
`ifdef MMU_MBIST_CKBD_EN
   localparam int unsigned DW    = 98;
   localparam int          NPASS = 2;
`else
   localparam int unsigned DW    = 88;
   localparam int          NPASS = 1;
`endif
   localparam int CLEAN_CYC = NPASS * 10 * DEPTH + int'(RD_LAT);

   logic          forever_clk = 1'b0;
   logic          forever_rst = 1'b1;
   logic          bist_start  = 1'b0;
   logic          bist_busy, bist_done, bist_pass;
   logic [AW-1:0] bist_fail_addr;
   logic [3:0]    bist_fail_elem;
   logic [AW-1:0] sram_a;
   logic          sram_cen, sram_gwen;
   logic [DW-1:0] sram_wen, sram_d, sram_q;

   int checks = 0;
   int errors = 0;

   int   fault_kind = 0;
   int   f_addr = 0, f_bit = 0, alias_a = 0;
   logic f_val = 1'b0;
   logic [DW-1:0] mem [DEPTH];

   c906_mmu_mbist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RD_LAT)) dut (
      .forever_clk    (forever_clk),
      .forever_rst    (forever_rst),
      .bist_start     (bist_start),
      .bist_busy      (bist_busy),
      .bist_done      (bist_done),
      .bist_pass      (bist_pass),
      .bist_fail_addr (bist_fail_addr),
      .bist_fail_elem (bist_fail_elem),
      .sram_a         (sram_a),
      .sram_cen       (sram_cen),
      .sram_gwen      (sram_gwen),
      .sram_wen       (sram_wen),
      .sram_d         (sram_d),
      .sram_q         (sram_q)
   );

   always #5 forever_clk = ~forever_clk;

   function automatic int map_row(input int a);
      return (fault_kind == 2 && a == alias_a) ? 0 : a;
   endfunction

   function automatic logic [DW-1:0] flt_read(input int row, input logic [DW-1:0] v);
      logic [DW-1:0] r;
      r = v;
      if (fault_kind == 1 && row == f_addr) r[f_bit] = f_val;
      return r;
   endfunction

   // Background word: pass 0 all zeros, pass 1 checkerboard 0x..5555 on even rows.
   function automatic logic [DW-1:0] bgw(input int p, input int a);
      logic [DW-1:0] w;
      w = '0;
      if (p == 1)
         for (int i = 0; i < int'(DW); i++) w[i] = ((i % 2) == 0) != ((a % 2) == 1);
      return w;
   endfunction

   // Single-port SRAM, one-cycle read latency.
   always @(posedge forever_clk) begin : sram_model
      int row;
      if (!sram_cen) begin
         row = map_row(int'(sram_a));
         if (!sram_gwen) mem[row] = (mem[row] & sram_wen) | (sram_d & ~sram_wen);
         else            sram_q <= flt_read(row, mem[row]);
      end
   end

   // March C- reference: returns first failing read and its op index from start.
   function automatic void model_run(output bit pass, output int faddr, output int felem,
                                     output int fop);
      logic [DW-1:0] m [DEPTH];
      logic [DW-1:0] v, x;
      int rdp [6];
      int wrp [6];
      int op, a;
      rdp = '{-1, 0, 1, 0, 1, 0};
      wrp = '{0, 1, 0, 1, 0, -1};
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
      pass = 1'b1; faddr = 0; felem = 0; fop = 0; op = 0;
      for (int p = 0; p < NPASS; p++)
         for (int e = 0; e < 6; e++)
            for (int i = 0; i < DEPTH; i++) begin
               a = (e == 3 || e == 4) ? DEPTH - 1 - i : i;
               if (rdp[e] >= 0) begin
                  x = bgw(p, a) ^ {DW{rdp[e] == 1}};
                  v = flt_read(map_row(a), m[map_row(a)]);
                  if (v !== x) begin
                     pass = 1'b0; faddr = a; felem = p * 8 + e; fop = op;
                     return;
                  end
                  op++;
               end
               if (wrp[e] >= 0) begin
                  m[map_row(a)] = bgw(p, a) ^ {DW{wrp[e] == 1}};
                  op++;
               end
            end
   endfunction

   // Pulse start, then count edges until done; optionally re-pulse start mid-run.
   task automatic run_bist(input int glitch_at, output int cyc, output int cen_low,
                           output logic [DW-1:0] dcap, output bit timeout);
      cyc = 0; cen_low = 0; dcap = '0; timeout = 1'b0;
      @(negedge forever_clk);
      bist_start = 1'b1;
      @(posedge forever_clk);
      @(negedge forever_clk);
      bist_start = 1'b0;
      if (!sram_cen) cen_low++;
      forever begin
         @(posedge forever_clk);
         cyc++;
         @(negedge forever_clk);
         if (!sram_cen) begin
            if (cen_low == 10 * DEPTH) dcap = sram_d;
            cen_low++;
         end
         bist_start = (cyc == glitch_at);
         if (bist_done) break;
         if (cyc > 3 * CLEAN_CYC) begin
            timeout = 1'b1;
            break;
         end
      end
      bist_start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge forever_clk);
      @(negedge forever_clk);
      forever_rst = 1'b0;
      checks++; if (sram_cen !== 1'b1) begin errors++; $display("FAIL reset_cen: got %b expected 1", sram_cen); end
      checks++; if (sram_gwen !== 1'b1) begin errors++; $display("FAIL reset_gwen: got %b expected 1", sram_gwen); end
      checks++; if (sram_wen !== {DW{1'b1}}) begin errors++; $display("FAIL reset_wen: got %h expected all ones", sram_wen); end
      checks++; if (sram_a !== '0) begin errors++; $display("FAIL reset_a: got %0d expected 0", sram_a); end
      checks++; if (sram_d !== '0) begin errors++; $display("FAIL reset_d: got %h expected 0", sram_d); end
      checks++; if ({bist_busy, bist_done, bist_pass} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {bist_busy, bist_done, bist_pass}); end
      checks++; if ({bist_fail_addr, bist_fail_elem} !== '0) begin errors++; $display("FAIL reset_fail_fields: got %0d/%0d expected 0/0", bist_fail_addr, bist_fail_elem); end
   endtask

   task automatic test_clean(input string nm, input int glitch_at);
      int cyc, cenl; logic [DW-1:0] dcap; bit to;
      fault_kind = 0;
      run_bist(glitch_at, cyc, cenl, dcap, to);
      checks++; if (to) begin errors++; $display("FAIL %s_timeout: no done after %0d cycles", nm, cyc); end
      checks++; if (cyc != CLEAN_CYC) begin errors++; $display("FAIL %s_cycles: got %0d expected %0d", nm, cyc, CLEAN_CYC); end
      checks++; if (cenl != NPASS * 10 * DEPTH) begin errors++; $display("FAIL %s_cen_low: got %0d expected %0d", nm, cenl, NPASS * 10 * DEPTH); end
      checks++; if (bist_pass !== 1'b1) begin errors++; $display("FAIL %s_pass: got %b expected 1", nm, bist_pass); end
      checks++; if (bist_busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b expected 0", nm, bist_busy); end
      checks++; if ({bist_fail_addr, bist_fail_elem} !== '0) begin errors++; $display("FAIL %s_fail_fields: got %0d/%0d expected 0/0", nm, bist_fail_addr, bist_fail_elem); end
      if (NPASS == 2) begin
         checks++; if (dcap !== bgw(1, 0)) begin errors++; $display("FAIL %s_ckbd_d: got %h expected %h", nm, dcap, bgw(1, 0)); end
      end
      repeat (3) @(negedge forever_clk);
      checks++; if (bist_done !== 1'b1 || bist_pass !== 1'b1) begin errors++; $display("FAIL %s_done_level: got %b%b expected 11", nm, bist_done, bist_pass); end
   endtask

   task automatic test_fault(input string nm);
      int cyc, cenl, ea, ee, eop; bit ep, to; logic [DW-1:0] dcap;
      model_run(ep, ea, ee, eop);
      run_bist(-1, cyc, cenl, dcap, to);
      checks++; if (to) begin errors++; $display("FAIL %s_timeout: no done after %0d cycles", nm, cyc); end
      checks++; if (bist_pass !== ep) begin errors++; $display("FAIL %s_pass: got %b expected %b", nm, bist_pass, ep); end
      if (!ep) begin
         checks++; if (int'(bist_fail_addr) != ea) begin errors++; $display("FAIL %s_addr: got %0d expected %0d", nm, bist_fail_addr, ea); end
         checks++; if (int'(bist_fail_elem) != ee) begin errors++; $display("FAIL %s_elem: got %0d expected %0d", nm, bist_fail_elem, ee); end
         checks++;
         if (cyc < eop + 1 + int'(RD_LAT) || cyc > eop + 2 + 2 * int'(RD_LAT)) begin
            errors++; $display("FAIL %s_latency: got %0d expected %0d..%0d", nm, cyc, eop + 1 + int'(RD_LAT), eop + 2 + 2 * int'(RD_LAT));
         end
      end
   endtask

   task automatic test_stuck(input int a, input int b, input logic v);
      fault_kind = 1; f_addr = a; f_bit = b; f_val = v;
      test_fault($sformatf("stuck_a%0d_b%0d_v%0d", a, b, v));
      fault_kind = 0;
   endtask

   task automatic test_alias(input int a);
      fault_kind = 2; alias_a = a;
      test_fault($sformatf("alias_a%0d", a));
      fault_kind = 0;
   endtask

   task automatic test_reset_midrun();
      fault_kind = 0;
      @(negedge forever_clk);
      bist_start = 1'b1;
      @(negedge forever_clk);
      bist_start = 1'b0;
      repeat (499) @(negedge forever_clk);
      checks++; if (bist_busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b expected 1", bist_busy); end
      forever_rst = 1'b1;
      @(negedge forever_clk);
      forever_rst = 1'b0;
      checks++; if (bist_busy !== 1'b0) begin errors++; $display("FAIL midrun_rst_busy: got %b expected 0", bist_busy); end
      checks++; if (sram_cen !== 1'b1 || sram_gwen !== 1'b1) begin errors++; $display("FAIL midrun_rst_cen: got %b%b expected 11", sram_cen, sram_gwen); end
      checks++; if (sram_wen !== {DW{1'b1}}) begin errors++; $display("FAIL midrun_rst_wen: got %h expected all ones", sram_wen); end
      checks++; if (bist_done !== 1'b0) begin errors++; $display("FAIL midrun_rst_done: got %b expected 0", bist_done); end
      test_clean("after_reset", -1);
   endtask

   initial begin
      test_reset();
      test_clean("clean", -1);
      test_stuck(37, 5, 1'b0);
      test_stuck(0, int'(DW) - 1, 1'b1);
      for (int i = 0; i < 4; i++)
         test_stuck(int'($urandom_range(DEPTH - 1)), int'($urandom_range(DW - 1)), 1'($urandom_range(1)));
      test_alias(64);
      test_alias(int'($urandom_range(DEPTH - 1, 1)));
      test_clean("back_to_back", -1);
      test_clean("start_ignored", 10);
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
